hilo_divider: RTL and testbench



---
 rtl/hilo_divider.sv | 155 +++++++++++++++
 tb/tb_hilo_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider
//  Purpose  : Iterative restoring divider for MIPS DIV / DIVU in the EX stage.
//             Produces one quotient bit per clock and delivers the packed
//             {hi, lo} = {remainder, quotient} pair for the HI/LO registers.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        clock
//    rst        in   1        asynchronous active-high reset
//    start      in   1        launch a division (sampled only in IDLE)
//    is_signed  in   1        1 = DIV (two's complement), 0 = DIVU
//    dividend   in   WIDTH    numerator, sampled with start
//    divisor    in   WIDTH    denominator, sampled with start
//    flush      in   1        abort the current operation
//    busy       out  1        operation in progress (pipeline stall)
//    done       out  1        one-cycle pulse, hl_result valid
//    hl_result  out  2*WIDTH  {remainder, quotient} = {hi, lo}
// ============================================================================
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] hl_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem_q;       // partial remainder
  logic [WIDTH-1:0] quo_q;       // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0] dvsr_q;      // |divisor|
  logic             signed_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;

  logic             launch;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             neg_quo;
  logic             neg_rem;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign launch = (state == S_IDLE) && start && !flush;

  // Magnitudes of the operands. The most negative value maps onto itself,
  // which is exactly its magnitude when read as unsigned.
  assign dvd_abs = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign dvs_abs = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor
  // with one extra bit of headroom on the shifted remainder.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, dvsr_q});
  // When the trial fits the difference is below the divisor, so WIDTH
  // bits hold it exactly.
  assign rem_diff = shifted[WIDTH-1:0] - dvsr_q;
  assign rem_nxt  = fits ? rem_diff : shifted[WIDTH-1:0];
  assign quo_nxt  = {quo_q[WIDTH-2:0], fits};

  // Sign fix-up on the final step. With a zero divisor the quotient stays
  // all ones; the remainder fix still runs because negating |dividend|
  // gives back the original dividend, which is the required hi value.
  assign neg_quo = signed_q && (dvd_neg_q ^ dvs_neg_q) && (dvsr_q != '0);
  assign neg_rem = signed_q && dvd_neg_q;
  assign quo_fix = neg_quo ? (~quo_nxt + 1'b1) : quo_nxt;
  assign rem_fix = neg_rem ? (~rem_nxt + 1'b1) : rem_nxt;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (launch) begin
          next_state = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          next_state = S_IDLE;
        end else if (counter == CNT_LAST) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hl_result <= '0;
      counter   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      done  <= (next_state == S_DONE);

      if (launch) begin
        signed_q  <= is_signed;
        dvd_neg_q <= is_signed && dividend[WIDTH-1];
        dvs_neg_q <= is_signed && divisor[WIDTH-1];
        quo_q     <= dvd_abs;
        dvsr_q    <= dvs_abs;
        rem_q     <= '0;
        counter   <= CNT_LOAD;
      end else if (state == S_CALC) begin
        rem_q   <= rem_nxt;
        quo_q   <= quo_nxt;
        counter <= counter - 1'b1;
      end

      if ((state == S_CALC) && (next_state == S_DONE)) begin
        hl_result <= {rem_fix, quo_fix};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_divider
//  Purpose  : Self-checking bench for hilo_divider: directed vector table
//             plus hand-written flush / start / reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] hl_result;

  int n_cmp  = 0;
  int n_fail = 0;

  hilo_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hl_result (hl_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch in the current cycle (cycle 0) and follow the op to cycle 34.
  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int          done_cyc;
    int          done_cnt;
    logic        busy_ok;
    logic [63:0] res;
    done_cyc = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    res      = '0;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (busy !== (c <= 33)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        res      = hl_result;
      end
      if (c < 34) tick();
    end
    check({name, " busy_window"}, 64'(busy_ok), 64'd1);
    check({name, " done_cycle"}, 64'(done_cyc), 64'd33);
    check({name, " done_count"}, 64'(done_cnt), 64'd1);
    check({name, " result"}, res, exp);
    check({name, " hold"}, hl_result, exp);
  endtask

  initial begin
    logic [63:0] prev;
    int          done_cnt;
    int          done_cyc;
    logic        busy_ok;
    logic [63:0] res;

    vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}};
    vecs[1]  = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{"div_7_m2",       1'b1, 32'h00000007,   32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    vecs[3]  = '{"div_overflow",   1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    vecs[4]  = '{"divu_8000_ffff", 1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}};
    vecs[5]  = '{"divu_by_zero",   1'b0, 32'h00001234,   32'h00000000, {32'h00001234, 32'hFFFFFFFF}};
    vecs[6]  = '{"div_by_zero",    1'b1, 32'hFFFFFFF0,   32'h00000000, {32'hFFFFFFF0, 32'hFFFFFFFF}};
    vecs[7]  = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}};
    vecs[8]  = '{"div_0_5",        1'b1, 32'h00000000,   32'h00000005, {32'h00000000, 32'h00000000}};
    vecs[9]  = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,   32'h00000001, {32'h00000000, 32'hFFFFFFFF}};
    vecs[10] = '{"divu_small_big", 1'b0, 32'h00000005,   32'hFFFFFFFF, {32'h00000005, 32'h00000000}};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hl_result", hl_result, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Flush mid-CALC, then a new op with an ignored start pulse while busy.
    prev      = hl_result;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    busy_ok  = 1'b1;
    done_cnt = 0;
    for (int c = 1; c < 10; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) done_cnt++;
      tick();
    end
    flush = 1'b1;
    if (done === 1'b1) done_cnt++;
    tick();
    flush = 1'b0;
    check("flush busy_before", 64'(busy_ok), 64'd1);
    check("flush busy_c11", 64'(busy), 64'd0);
    if (done === 1'b1) done_cnt++;
    tick();
    check("flush busy_c12", 64'(busy), 64'd0);
    if (done === 1'b1) done_cnt++;
    check("flush no_done", 64'(done_cnt), 64'd0);
    check("flush hl_kept", hl_result, prev);

    dividend = 32'd9;
    divisor  = 32'd4;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    busy_ok  = 1'b1;
    done_cnt = 0;
    done_cyc = 0;
    res      = '0;
    for (int c = 13; c <= 46; c++) begin
      if (busy !== (c <= 45)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        res      = hl_result;
      end
      if (c == 20) begin
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c < 46) tick();
    end
    start = 1'b0;
    check("restart busy_window", 64'(busy_ok), 64'd1);
    check("restart done_cycle", 64'(done_cyc), 64'd45);
    check("restart done_count", 64'(done_cnt), 64'd1);
    check("restart result", res, {32'd1, 32'd2});

    // start and flush together in IDLE: nothing launches.
    prev      = hl_result;
    dividend  = 32'd50;
    divisor   = 32'd3;
    start     = 1'b1;
    flush     = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    busy_ok  = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b0) busy_ok = 1'b0;
      if (done === 1'b1) done_cnt++;
      tick();
    end
    check("start_flush idle_busy", 64'(busy_ok), 64'd1);
    check("start_flush no_done", 64'(done_cnt), 64'd0);
    check("start_flush hl_kept", hl_result, prev);

    // Asynchronous reset in cycle 15 of CALC.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("pre_rst busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    check("async_rst hl_result", hl_result, 64'd0);
    tick();
    rst = 1'b0;
    check("held_rst hl_result", hl_result, 64'd0);
    tick();
    run_op("post_rst divu", 1'b0, 32'hFFFFFFFF, 32'h00000010, {32'h0000000F, 32'h0FFFFFFF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
